// File: rtl/reg_scoreboard_pkg.sv
// Shared types and constants for the register-write scoreboard.
// Defaults describe the 32-entry MIPS register file with 2-bit in-flight counters.
package reg_scoreboard_pkg;

    localparam int REG_INDEX_WIDTH = 5;
    localparam int REG_COUNT_WIDTH = 2;

    typedef logic [REG_INDEX_WIDTH-1:0] reg_index_t;
    typedef logic [REG_COUNT_WIDTH-1:0] count_t;

    localparam reg_index_t REG_ZERO             = '0;
    localparam count_t     SCOREBOARD_MAX_COUNT = '1;

endpackage

// File: rtl/onehot_decoder.sv
// Generic binary-to-one-hot decoder with an enable; all-zero output when disabled.
module onehot_decoder
    import reg_scoreboard_pkg::*;
#(
    parameter int IN_WIDTH = REG_INDEX_WIDTH
) (
    input  logic                     enable,
    input  logic [IN_WIDTH-1:0]      index,
    output logic [2**IN_WIDTH-1:0]   onehot
);

    always_comb begin
        // NOTE: default first so every path assigns onehot and no latch is inferred.
        onehot = '0;
        if (enable) begin
            onehot[index] = 1'b1;
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// Register-write scoreboard: per-register in-flight counters, hazard queries, busy mask.
// Optional macro SCOREBOARD_RETIRE_BYPASS_EN lets a final retire clear query_busy the same cycle.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int INDEX_WIDTH          = REG_INDEX_WIDTH,
    parameter int COUNT_WIDTH          = REG_COUNT_WIDTH,
    parameter int QUERY_PORTS          = 2,
    parameter int ZERO_INDEX_HARDWIRED = 1
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               flush,
    input  logic                               issue_valid,
    input  logic [INDEX_WIDTH-1:0]             issue_index,
    output logic                               issue_ready,
    input  logic                               retire_valid,
    input  logic [INDEX_WIDTH-1:0]             retire_index,
    input  logic [QUERY_PORTS*INDEX_WIDTH-1:0] query_index,
    output logic [QUERY_PORTS-1:0]             query_busy,
    output logic [2**INDEX_WIDTH-1:0]          busy_mask,
    output logic                               underflow_err
);

    localparam int                     ENTRIES   = 2**INDEX_WIDTH;
    localparam logic [COUNT_WIDTH-1:0] MAX_COUNT = '1;

    logic [COUNT_WIDTH-1:0] count_q [ENTRIES];
    logic [ENTRIES-1:0]     issue_hit;
    logic [ENTRIES-1:0]     retire_hit;
    logic [ENTRIES-1:0]     underflow_hit;
    logic                   issue_accept;

    // Ready looks only at stored state, so issue_valid never reaches issue_ready.
    assign issue_ready  = (count_q[issue_index] != MAX_COUNT);
    assign issue_accept = issue_valid && issue_ready;

    onehot_decoder #(.IN_WIDTH(INDEX_WIDTH)) u_issue_dec (
        .enable (issue_accept),
        .index  (issue_index),
        .onehot (issue_hit)
    );

    onehot_decoder #(.IN_WIDTH(INDEX_WIDTH)) u_retire_dec (
        .enable (retire_valid),
        .index  (retire_index),
        .onehot (retire_hit)
    );

    for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
        // $zero keeps a counter that can never move, so it folds to constant 0.
        localparam bit TRACKED = !(ZERO_INDEX_HARDWIRED != 0 && i == 0);

        logic inc;
        logic dec;

        assign inc = TRACKED && issue_hit[i];
        assign dec = TRACKED && retire_hit[i];

        // NOTE: counters are plain flops, so each is reset; non-blocking keeps updates edge-ordered.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                count_q[i] <= '0;
            end else if (flush) begin
                count_q[i] <= '0;
            end else if (inc && !dec) begin
                count_q[i] <= count_q[i] + 1'b1;
            end else if (dec && !inc && count_q[i] != '0) begin
                count_q[i] <= count_q[i] - 1'b1;
            end
        end

        assign underflow_hit[i] = dec && !inc && (count_q[i] == '0) && !flush;
        assign busy_mask[i]     = (count_q[i] != '0);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            underflow_err <= 1'b0;
        end else if (|underflow_hit) begin
            underflow_err <= 1'b1;
        end
    end

    for (genvar p = 0; p < QUERY_PORTS; p++) begin : g_query
        logic [INDEX_WIDTH-1:0] qidx;

        assign qidx = query_index[p*INDEX_WIDTH +: INDEX_WIDTH];

`ifdef SCOREBOARD_RETIRE_BYPASS_EN
        // A retire draining the last pending write forwards its result this cycle.
        assign query_busy[p] = busy_mask[qidx] &&
                               !(retire_valid && !flush && (retire_index == qidx) &&
                                 (count_q[qidx] == COUNT_WIDTH'(1)));
`else
        assign query_busy[p] = busy_mask[qidx];
`endif
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed scenarios plus randomized traffic
// against a per-register pending-write count model.
module tb_reg_scoreboard;
    import reg_scoreboard_pkg::*;

    localparam int IW      = 5;
    localparam int ENTRIES = 32;
    localparam int MAXC    = int'(SCOREBOARD_MAX_COUNT);

    logic              clock = 1'b0;
    logic              reset;
    logic              flush;
    logic              issue_valid;
    logic [IW-1:0]     issue_index;
    logic              issue_ready;
    logic              retire_valid;
    logic [IW-1:0]     retire_index;
    logic [2*IW-1:0]   query_index;
    logic [1:0]        query_busy;
    logic [ENTRIES-1:0] busy_mask;
    logic              underflow_err;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: number of outstanding writes per register, plus sticky error.
    int unsigned pending [ENTRIES];
    bit          model_err;

    reg_scoreboard dut (
        .clock         (clock),
        .reset         (reset),
        .flush         (flush),
        .issue_valid   (issue_valid),
        .issue_index   (issue_index),
        .issue_ready   (issue_ready),
        .retire_valid  (retire_valid),
        .retire_index  (retire_index),
        .query_index   (query_index),
        .query_busy    (query_busy),
        .busy_mask     (busy_mask),
        .underflow_err (underflow_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < ENTRIES; i++) pending[i] = 0;
    endtask

    function automatic bit model_ready(input int idx);
        return (idx == 0) || (pending[idx] < MAXC);
    endfunction

    function automatic bit model_qbusy(input int q);
        bit busy;
        busy = (pending[q] != 0);
`ifdef SCOREBOARD_RETIRE_BYPASS_EN
        if (retire_valid && !flush && int'(retire_index) == q && pending[q] == 1) busy = 0;
`endif
        return busy;
    endfunction

    task automatic compare_outputs(input string tag);
        logic [ENTRIES-1:0] exp_mask;
        logic [1:0]         exp_qb;
        for (int i = 0; i < ENTRIES; i++) exp_mask[i] = (pending[i] != 0);
        exp_qb[0] = model_qbusy(int'(query_index[IW-1:0]));
        exp_qb[1] = model_qbusy(int'(query_index[2*IW-1:IW]));
        check({tag, ".busy_mask"},   64'(busy_mask),     64'(exp_mask));
        check({tag, ".issue_ready"}, 64'(issue_ready),   64'(model_ready(int'(issue_index))));
        check({tag, ".query_busy"},  64'(query_busy),    64'(exp_qb));
        check({tag, ".underflow"},   64'(underflow_err), 64'(model_err));
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        int  ii, ri;
        bit  acc;
        ii  = int'(issue_index);
        ri  = int'(retire_index);
        acc = issue_valid && model_ready(ii);
        if (flush) begin
            model_clear();
        end else if (acc && retire_valid && ii == ri) begin
            // matched issue and retire cancel out
        end else begin
            if (acc && ii != 0) pending[ii]++;
            if (retire_valid && ri != 0) begin
                if (pending[ri] > 0) pending[ri]--;
                else model_err = 1;
            end
        end
    endtask

    task automatic step(input string tag, input bit iv, input int ii, input bit rv, input int ri,
                        input bit fl, input int q0, input int q1);
        @(negedge clock);
        issue_valid  = iv;
        issue_index  = IW'(ii);
        retire_valid = rv;
        retire_index = IW'(ri);
        flush        = fl;
        query_index  = {IW'(q1), IW'(q0)};
        #1;
        compare_outputs(tag);
        @(posedge clock);
        model_edge();
    endtask

    initial begin
        reset        = 1'b1;
        flush        = 1'b0;
        issue_valid  = 1'b0;
        issue_index  = '0;
        retire_valid = 1'b0;
        retire_index = '0;
        query_index  = '0;
        model_clear();
        model_err = 0;

        repeat (2) @(negedge clock);
        #1;
        compare_outputs("reset");
        @(negedge clock);
        reset = 1'b0;

        // Fill register 7, then a fourth issue must be refused.
        for (int k = 0; k < 3; k++) step("issue7", 1, 7, 0, 0, 0, 7, 0);
        step("issue7_full", 1, 7, 0, 0, 0, 7, 7);
        check("full7.ready", 64'(issue_ready), 64'd0);
        for (int k = 0; k < 3; k++) step("retire7", 0, 7, 1, 7, 0, 7, 0);
        step("drained7", 0, 7, 0, 0, 0, 7, 7);
        check("drained7.mask", 64'(busy_mask[7]), 64'd0);

        // Simultaneous issue/retire to register 9 keeps it pending.
        step("issue9", 1, 9, 0, 0, 0, 9, 9);
        step("both9", 1, 9, 1, 9, 0, 9, 9);
        step("after9", 0, 0, 0, 0, 0, 9, 9);
        check("after9.qbusy", 64'(query_busy), 64'd3);

        // Idle retire raises the sticky error; issue to $zero has no effect.
        step("retire4", 0, 0, 1, 4, 0, 4, 0);
        step("issue0", 1, 0, 0, 0, 0, 0, 4);
        step("zero_idle", 1, 0, 1, 0, 0, 0, 0);
        check("sticky.err", 64'(underflow_err), 64'd1);

        // Five busy registers, then flush overrides a same-cycle issue.
        step("fill1", 1, 1, 0, 0, 0, 1, 2);
        step("fill2", 1, 2, 0, 0, 0, 1, 2);
        step("fill5", 1, 5, 0, 0, 0, 5, 6);
        step("fill6", 1, 6, 0, 0, 0, 5, 6);
        step("flush", 1, 3, 1, 1, 1, 3, 9);
        step("post_flush", 0, 0, 0, 0, 0, 3, 9);
        check("flush.mask", 64'(busy_mask), 64'd0);

        // Last retire to register 12 with a query on port 1.
        step("issue12", 1, 12, 0, 0, 0, 0, 12);
        step("retire12", 0, 0, 1, 12, 0, 12, 12);
        step("idle12", 0, 12, 0, 0, 0, 12, 12);

        // Randomized traffic concentrated on a few registers so counters saturate.
        for (int n = 0; n < 1500; n++) begin
            step("rand",
                 bit'($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)),
                 bit'($urandom_range(0, 2) != 0), int'($urandom_range(0, 7)),
                 bit'($urandom_range(0, 40) == 0),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
        end

        // Asynchronous reset between edges clears everything at once.
        for (int k = 0; k < 4; k++) step("prefill", 1, 10 + k, 0, 0, 0, 10, 11);
        @(negedge clock);
        issue_valid  = 1'b0;
        retire_valid = 1'b0;
        flush        = 1'b0;
        issue_index  = IW'(10);
        #2;
        reset = 1'b1;
        #1;
        model_clear();
        model_err = 0;
        compare_outputs("async_reset");
        @(negedge clock);
        reset = 1'b0;
        step("after_reset", 1, 10, 0, 0, 0, 10, 0);
        step("after_reset2", 0, 10, 0, 0, 0, 10, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
